// File: rtl/l1d_l1i_mem_arb.sv
// Arbitrates L1D/L1I misses onto a single L2 request port and sequences L1/L2 flushes.
// Optional L1_ARB_ROUND_ROBIN_EN: alternate tie-break on last grant instead of fixed L1D priority.
module l1d_l1i_mem_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CL_W   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l1d_mem_req_valid,
  input  logic [ADDR_W-1:0] l1d_mem_req_addr,
  input  logic [3:0]        l1d_mem_req_opcode,
  input  logic [CL_W-1:0]   l1d_mem_req_store_data,
  input  logic              l1i_mem_req_valid,
  input  logic [ADDR_W-1:0] l1i_mem_req_addr,
  input  logic [3:0]        l1i_mem_req_opcode,
  output logic              l2_req_valid,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [3:0]        l2_req_opcode,
  output logic [CL_W-1:0]   l2_req_store_data,
  input  logic              l2_req_ack,
  input  logic              l2_rsp_valid,
  input  logic [CL_W-1:0]   l2_rsp_load_data,
  output logic              l1d_mem_rsp_valid,
  output logic              l1i_mem_rsp_valid,
  output logic [CL_W-1:0]   l1_rsp_load_data,
  input  logic              flush_req_l1d,
  input  logic              flush_req_l1i,
  input  logic              l1d_flush_complete,
  input  logic              l1i_flush_complete,
  input  logic              l2_flush_complete,
  output logic              flush_l2,
  output logic              in_flush_mode
);

  typedef enum logic [1:0] {IDLE, GNT_L1D, GNT_L1I} arb_state_e;
  typedef enum logic [2:0] {F_IDLE, WAIT_BOTH, WAIT_L1I, WAIT_L1D, FLUSH_L2} flush_state_e;

  arb_state_e   arb_q, arb_d;
  flush_state_e flush_q, flush_d;
  logic         pend_d_q, pend_d_d;
  logic         pend_i_q, pend_i_d;
  logic         req_q, req_d;
  logic         flush_l2_q, flush_l2_d;
  logic         in_flush_q, in_flush_d;
  logic         pend_d, pend_i, gnt_i, tie_to_i;
`ifdef L1_ARB_ROUND_ROBIN_EN
  logic         last_gnt_q, last_gnt_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_q      <= IDLE;
      flush_q    <= F_IDLE;
      pend_d_q   <= 1'b0;
      pend_i_q   <= 1'b0;
      req_q      <= 1'b0;
      flush_l2_q <= 1'b0;
      in_flush_q <= 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
      last_gnt_q <= 1'b0;
`endif
    end else begin
      arb_q      <= arb_d;
      flush_q    <= flush_d;
      pend_d_q   <= pend_d_d;
      pend_i_q   <= pend_i_d;
      req_q      <= req_d;
      flush_l2_q <= flush_l2_d;
      in_flush_q <= in_flush_d;
`ifdef L1_ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  // Arbiter: sticky pending flags, one outstanding L2 transaction at a time
  always_comb begin
    pend_d            = pend_d_q | l1d_mem_req_valid;
    pend_i            = pend_i_q | l1i_mem_req_valid;
`ifdef L1_ARB_ROUND_ROBIN_EN
    tie_to_i          = ~last_gnt_q;
    last_gnt_d        = last_gnt_q;
`else
    tie_to_i          = 1'b0;
`endif
    gnt_i             = pend_i & (~pend_d | tie_to_i);
    arb_d             = arb_q;
    pend_d_d          = pend_d;
    pend_i_d          = pend_i;
    req_d             = req_q;
    l1d_mem_rsp_valid = 1'b0;
    l1i_mem_rsp_valid = 1'b0;
    case (arb_q)
      IDLE: begin
        if (pend_d || pend_i) begin
          arb_d = gnt_i ? GNT_L1I : GNT_L1D;
          req_d = 1'b1;
        end
      end
      GNT_L1D: begin
        pend_d_d = 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
        last_gnt_d = 1'b0;
`endif
        if (l2_req_ack) req_d = 1'b0;
        if (l2_rsp_valid) begin
          l1d_mem_rsp_valid = 1'b1;
          req_d             = 1'b0;
          arb_d             = IDLE;
        end
      end
      GNT_L1I: begin
        pend_i_d = 1'b0;
`ifdef L1_ARB_ROUND_ROBIN_EN
        last_gnt_d = 1'b1;
`endif
        if (l2_req_ack) req_d = 1'b0;
        if (l2_rsp_valid) begin
          l1i_mem_rsp_valid = 1'b1;
          req_d             = 1'b0;
          arb_d             = IDLE;
        end
      end
      default: arb_d = IDLE;
    endcase
  end

  // Flush sequencer: wait for the requested L1 flushes, then pulse the L2 flush
  always_comb begin
    flush_d = flush_q;
    case (flush_q)
      F_IDLE: begin
        if (flush_req_l1d && flush_req_l1i) flush_d = WAIT_BOTH;
        else if (flush_req_l1i)             flush_d = WAIT_L1I;
        else if (flush_req_l1d)             flush_d = WAIT_L1D;
      end
      WAIT_BOTH: begin
        if (l1d_flush_complete && l1i_flush_complete) flush_d = FLUSH_L2;
        else if (l1d_flush_complete)                  flush_d = WAIT_L1I;
        else if (l1i_flush_complete)                  flush_d = WAIT_L1D;
      end
      WAIT_L1I: if (l1i_flush_complete) flush_d = FLUSH_L2;
      WAIT_L1D: if (l1d_flush_complete) flush_d = FLUSH_L2;
      FLUSH_L2: if (l2_flush_complete)  flush_d = F_IDLE;
      default:  flush_d = F_IDLE;
    endcase
    flush_l2_d = (flush_d == FLUSH_L2) && (flush_q != FLUSH_L2);
    in_flush_d = (flush_d != F_IDLE);
  end

  assign l2_req_valid      = req_q;
  assign l2_req_addr       = (arb_q == GNT_L1I) ? l1i_mem_req_addr : l1d_mem_req_addr;
  assign l2_req_opcode     = (arb_q == GNT_L1I) ? l1i_mem_req_opcode : l1d_mem_req_opcode;
  assign l2_req_store_data = l1d_mem_req_store_data;
  assign l1_rsp_load_data  = l2_rsp_load_data;
  assign flush_l2          = flush_l2_q;
  assign in_flush_mode     = in_flush_q;

endmodule

// File: tb/tb_l1d_l1i_mem_arb.sv
// Cycle-vector bench for l1d_l1i_mem_arb with a scoreboard of per-cycle expected outputs.
module tb_l1d_l1i_mem_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 128;
  localparam logic [AW-1:0] D_ADDR = 32'h0000_1000;
  localparam logic [AW-1:0] I_ADDR = 32'h0000_2000;
  localparam logic [3:0]    D_OP   = 4'd4;
  localparam logic [3:0]    I_OP   = 4'd2;

  logic clk = 1'b0;
  logic reset;
  logic l1d_mem_req_valid, l1i_mem_req_valid;
  logic [AW-1:0] l1d_mem_req_addr, l1i_mem_req_addr;
  logic [3:0] l1d_mem_req_opcode, l1i_mem_req_opcode;
  logic [CW-1:0] l1d_mem_req_store_data;
  logic l2_req_valid;
  logic [AW-1:0] l2_req_addr;
  logic [3:0] l2_req_opcode;
  logic [CW-1:0] l2_req_store_data;
  logic l2_req_ack, l2_rsp_valid;
  logic [CW-1:0] l2_rsp_load_data;
  logic l1d_mem_rsp_valid, l1i_mem_rsp_valid;
  logic [CW-1:0] l1_rsp_load_data;
  logic flush_req_l1d, flush_req_l1i;
  logic l1d_flush_complete, l1i_flush_complete, l2_flush_complete;
  logic flush_l2, in_flush_mode;

  l1d_l1i_mem_arb #(.ADDR_W(AW), .CL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .l1d_mem_req_valid(l1d_mem_req_valid), .l1d_mem_req_addr(l1d_mem_req_addr),
    .l1d_mem_req_opcode(l1d_mem_req_opcode), .l1d_mem_req_store_data(l1d_mem_req_store_data),
    .l1i_mem_req_valid(l1i_mem_req_valid), .l1i_mem_req_addr(l1i_mem_req_addr),
    .l1i_mem_req_opcode(l1i_mem_req_opcode),
    .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_opcode(l2_req_opcode),
    .l2_req_store_data(l2_req_store_data), .l2_req_ack(l2_req_ack),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_load_data(l2_rsp_load_data),
    .l1d_mem_rsp_valid(l1d_mem_rsp_valid), .l1i_mem_rsp_valid(l1i_mem_rsp_valid),
    .l1_rsp_load_data(l1_rsp_load_data),
    .flush_req_l1d(flush_req_l1d), .flush_req_l1i(flush_req_l1i),
    .l1d_flush_complete(l1d_flush_complete), .l1i_flush_complete(l1i_flush_complete),
    .l2_flush_complete(l2_flush_complete), .flush_l2(flush_l2), .in_flush_mode(in_flush_mode)
  );

  always #5 clk = ~clk;

  // Inputs: dv iv ack rsp | frd fri | fcd fci fcl2
  typedef struct packed {
    logic dv, iv, ack, rsp, frd, fri, fcd, fci, fcl2;
  } in_t;
  // Expected: req_valid sel_l1i | d_rsp i_rsp | flush_l2 in_flush
  typedef struct packed {
    logic rv, seli, drsp, irsp, fl2, infl;
  } exp_t;
  typedef struct {
    in_t   i;
    exp_t  e;
    string nm;
  } vec_t;
  typedef struct {
    exp_t          e;
    logic [CW-1:0] ld;
    logic [CW-1:0] sd;
    string         nm;
  } sb_t;

  vec_t tv[$];
  sb_t  sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [40:0] ctl_exp(input exp_t e);
    return {e.rv, e.seli ? I_ADDR : D_ADDR, e.seli ? I_OP : D_OP, e.drsp, e.irsp, e.fl2, e.infl};
  endfunction

  function automatic logic [40:0] ctl_act();
    return {l2_req_valid, l2_req_addr, l2_req_opcode, l1d_mem_rsp_valid, l1i_mem_rsp_valid,
            flush_l2, in_flush_mode};
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [8:0] i, input logic [5:0] e);
    vec_t v;
    v.i  = in_t'(i);
    v.e  = exp_t'(e);
    v.nm = nm;
    tv.push_back(v);
  endtask

  task automatic run_table();
    sb_t s;
    for (int k = 0; k < tv.size(); k++) begin
      @(posedge clk);
      #1;
      l1d_mem_req_valid      = tv[k].i.dv;
      l1i_mem_req_valid      = tv[k].i.iv;
      l2_req_ack             = tv[k].i.ack;
      l2_rsp_valid           = tv[k].i.rsp;
      flush_req_l1d          = tv[k].i.frd;
      flush_req_l1i          = tv[k].i.fri;
      l1d_flush_complete     = tv[k].i.fcd;
      l1i_flush_complete     = tv[k].i.fci;
      l2_flush_complete      = tv[k].i.fcl2;
      l2_rsp_load_data       = {$urandom, $urandom, $urandom, $urandom};
      l1d_mem_req_store_data = {$urandom, $urandom, $urandom, $urandom};
      s.e  = tv[k].e;
      s.ld = l2_rsp_load_data;
      s.sd = l1d_mem_req_store_data;
      s.nm = tv[k].nm;
      sb.push_back(s);
      @(negedge clk);
      s = sb.pop_front();
      chk(s.nm, CW'(ctl_act()), CW'(ctl_exp(s.e)));
      chk({s.nm, "_data"}, l1_rsp_load_data ^ l2_req_store_data, s.ld ^ s.sd);
    end
    tv.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    l1d_mem_req_valid = 1'b0; l1i_mem_req_valid = 1'b0;
    l1d_mem_req_addr = D_ADDR; l1d_mem_req_opcode = D_OP;
    l1i_mem_req_addr = I_ADDR; l1i_mem_req_opcode = I_OP;
    l1d_mem_req_store_data = '0; l2_rsp_load_data = '0;
    l2_req_ack = 1'b0; l2_rsp_valid = 1'b0;
    flush_req_l1d = 1'b0; flush_req_l1i = 1'b0;
    l1d_flush_complete = 1'b0; l1i_flush_complete = 1'b0; l2_flush_complete = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", CW'(ctl_act()), CW'(ctl_exp(exp_t'(6'b0))));
    @(posedge clk);
    #1 reset = 1'b1;

    // Single L1D transaction; response in IDLE is ignored
    add("a0", 9'b1000_00_000, 6'b00_00_00);
    add("a1", 9'b0000_00_000, 6'b10_00_00);
    add("a2", 9'b0010_00_000, 6'b10_00_00);
    add("a3", 9'b0000_00_000, 6'b00_00_00);
    add("a4", 9'b0001_00_000, 6'b00_10_00);
    add("a5", 9'b0001_00_000, 6'b00_00_00);
    // Simultaneous requests: tie-break then the loser is served from its sticky flag
    add("b0", 9'b1100_00_000, 6'b00_00_00);
`ifdef L1_ARB_ROUND_ROBIN_EN
    add("b1", 9'b0000_00_000, 6'b11_00_00);
    add("b2", 9'b0010_00_000, 6'b11_00_00);
    add("b3", 9'b0001_00_000, 6'b01_01_00);
    add("b4", 9'b0000_00_000, 6'b00_00_00);
    add("b5", 9'b0000_00_000, 6'b10_00_00);
    add("b6", 9'b0010_00_000, 6'b10_00_00);
    add("b7", 9'b0001_00_000, 6'b00_10_00);
`else
    add("b1", 9'b0000_00_000, 6'b10_00_00);
    add("b2", 9'b0010_00_000, 6'b10_00_00);
    add("b3", 9'b0001_00_000, 6'b00_10_00);
    add("b4", 9'b0000_00_000, 6'b00_00_00);
    add("b5", 9'b0000_00_000, 6'b11_00_00);
    add("b6", 9'b0010_00_000, 6'b11_00_00);
    add("b7", 9'b0001_00_000, 6'b01_01_00);
`endif
    add("b8", 9'b0000_00_000, 6'b00_00_00);
    // Valids during GNT_L1D: L1I latched, L1D dropped
    add("c0", 9'b1000_00_000, 6'b00_00_00);
    add("c1", 9'b1100_00_000, 6'b10_00_00);
    add("c2", 9'b0010_00_000, 6'b10_00_00);
    add("c3", 9'b0001_00_000, 6'b00_10_00);
    add("c4", 9'b0000_00_000, 6'b00_00_00);
    add("c5", 9'b0000_00_000, 6'b11_00_00);
    add("c6", 9'b0010_00_000, 6'b11_00_00);
    add("c7", 9'b0001_00_000, 6'b01_01_00);
    add("c8", 9'b0000_00_000, 6'b00_00_00);
    add("c9", 9'b0000_00_000, 6'b00_00_00);
    // Dual flush, l1i done t=3, l1d done t=6, with an L1D transaction overlapping
    add("d0", 9'b0000_11_000, 6'b00_00_00);
    add("d1", 9'b0000_00_000, 6'b00_00_01);
    add("d2", 9'b1000_00_000, 6'b00_00_01);
    add("d3", 9'b0010_00_010, 6'b10_00_01);
    add("d4", 9'b0000_00_000, 6'b00_00_01);
    add("d5", 9'b0001_00_000, 6'b00_10_01);
    add("d6", 9'b0000_00_100, 6'b00_00_01);
    add("d7", 9'b0000_00_000, 6'b00_00_11);
    add("d8", 9'b0000_00_000, 6'b00_00_01);
    add("d9", 9'b0000_00_001, 6'b00_00_01);
    add("d10", 9'b0000_00_000, 6'b00_00_00);
    // L1I-only flush; stray completes ignored
    add("e0", 9'b0000_01_000, 6'b00_00_00);
    add("e1", 9'b0000_00_100, 6'b00_00_01);
    add("e2", 9'b0000_00_001, 6'b00_00_01);
    add("e3", 9'b0000_00_010, 6'b00_00_01);
    add("e4", 9'b0000_00_000, 6'b00_00_11);
    add("e5", 9'b0000_00_000, 6'b00_00_01);
    add("e6", 9'b0000_00_001, 6'b00_00_01);
    add("e7", 9'b0000_00_000, 6'b00_00_00);
    // Both L1 completes in the same cycle
    add("f0", 9'b0000_11_000, 6'b00_00_00);
    add("f1", 9'b0000_00_110, 6'b00_00_01);
    add("f2", 9'b0000_00_000, 6'b00_00_11);
    add("f3", 9'b0000_00_001, 6'b00_00_01);
    add("f4", 9'b0000_00_000, 6'b00_00_00);
    // L1D-only flush, L2 complete on the first FLUSH_L2 cycle
    add("g0", 9'b0000_10_000, 6'b00_00_00);
    add("g1", 9'b0000_00_100, 6'b00_00_01);
    add("g2", 9'b0000_00_001, 6'b00_00_11);
    add("g3", 9'b0000_00_000, 6'b00_00_00);
    // Enter GNT_L1I with r_req=1 and a flush in progress
    add("r0", 9'b0100_01_000, 6'b00_00_00);
    add("r1", 9'b0000_00_000, 6'b11_00_01);
    run_table();

    // Asynchronous reset mid-transaction
    #2;
    reset = 1'b0;
    l2_rsp_valid = 1'b1;
    #1;
    chk("async_reset", CW'(ctl_act()), CW'(ctl_exp(exp_t'(6'b0))));
    @(posedge clk);
    #1 reset = 1'b1;
    add("r2", 9'b0001_00_000, 6'b00_00_00);
    add("r3", 9'b0001_00_000, 6'b00_00_00);
    add("r4", 9'b0000_00_000, 6'b00_00_00);
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
